// File: rtl/shared_adder_scheduler.sv
// Two-requester adder scheduler built around one time-shared HALF-bit adder.
// Each add takes a low-half pass and a high-half pass; arbitration is round-robin.
module shared_adder_scheduler #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_cout,
    output logic             rsp_id
);

    localparam int unsigned HALF = WIDTH / 2;

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_id;
    logic             carry;
    logic [HALF-1:0]  sum_lo;
    logic             last_grant;

    logic             grant;
    logic [HALF-1:0]  add_a;
    logic [HALF-1:0]  add_b;
    logic             add_cin;
    logic [HALF:0]    add_out;

    // Round-robin pick: on contention, the requester not granted last wins.
    always_comb begin
        grant = req1_valid;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant;
        end
    end

    assign req0_ready = (state == IDLE) && !reset && req0_valid && !grant;
    assign req1_ready = (state == IDLE) && !reset && req1_valid &&  grant;

    // The single shared adder: low half with cin=0, high half with the stored carry.
    always_comb begin
        add_a   = op_a[HALF-1:0];
        add_b   = op_b[HALF-1:0];
        add_cin = 1'b0;
        if (state == HIGH) begin
            add_a   = op_a[WIDTH-1:HALF];
            add_b   = op_b[WIDTH-1:HALF];
            add_cin = carry;
        end
        add_out = {1'b0, add_a} + {1'b0, add_b} + {{HALF{1'b0}}, add_cin};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            op_a       <= '0;
            op_b       <= '0;
            op_id      <= 1'b0;
            carry      <= 1'b0;
            sum_lo     <= '0;
            last_grant <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_sum    <= '0;
            rsp_cout   <= 1'b0;
            rsp_id     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0_ready || req1_ready) begin
                        op_a       <= req1_ready ? req1_a : req0_a;
                        op_b       <= req1_ready ? req1_b : req0_b;
                        op_id      <= req1_ready;
                        last_grant <= req1_ready;
                        state      <= LOW;
                    end
                end
                LOW: begin
                    sum_lo <= add_out[HALF-1:0];
                    carry  <= add_out[HALF];
                    state  <= HIGH;
                end
                HIGH: begin
                    rsp_sum   <= {add_out[HALF-1:0], sum_lo};
                    rsp_cout  <= add_out[HALF];
                    rsp_id    <= op_id;
                    rsp_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
